// File: rtl/decoder_param_seq_if.sv
// Command/select bundle between a control FSM and the registered one-hot decoder.
// The master drives the command fields; the slave (decoder) drives the select and status flags.
interface decoder_param_seq_if #(
    parameter int BITS = 2,
    parameter int SIZE = 4
) ();
    logic [BITS-1:0] in_i;
    logic            en_i;
    logic [1:0]      mode_i;
    logic [SIZE-1:0] out_o;
    logic [BITS-1:0] idx_o;
    logic            busy_o;
    logic            err_o;
    logic            drop_o;

    modport master (
        output in_i, en_i, mode_i,
        input  out_o, idx_o, busy_o, err_o, drop_o
    );

    modport slave (
        input  in_i, en_i, mode_i,
        output out_o, idx_o, busy_o, err_o, drop_o
    );
endinterface

// File: rtl/decoder_param_seq.sv
// Registered one-hot decoder with LEVEL/PULSE/STEP/CLEAR commands.
// Selects are glitch-free flops; the pulse timer is a down-counter that ends on zero.
//
// state   | meaning
// S_IDLE  | no select asserted, commands accepted
// S_LATCH | one-hot of idx held until the next command
// S_PULSE | one-hot of idx held while the counter runs down; commands dropped
module decoder_param_seq #(
    parameter int BITS      = 2,
    parameter int SIZE      = 4,
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = 4
) (
    input logic                 clk,
    input logic                 rst,
    decoder_param_seq_if.slave  bus
);
    if (SIZE > (1 << BITS)) begin : g_bad_size
        $error("decoder_param_seq: SIZE must not exceed 2**BITS");
    end
    if (PULSE_LEN < 1 || PULSE_LEN > (1 << CNT_W) - 1) begin : g_bad_pulse
        $error("decoder_param_seq: PULSE_LEN must be in 1..2**CNT_W-1");
    end

    localparam logic [1:0]  MODE_LEVEL = 2'b00;
    localparam logic [1:0]  MODE_PULSE = 2'b01;
    localparam logic [1:0]  MODE_STEP  = 2'b10;
    localparam logic [31:0] SIZE_U     = SIZE;

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_PULSE} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS-1:0] idx_q, idx_d;
    logic [SIZE-1:0] out_q, out_d;
    logic            err_q, err_d;
    logic            drop_q, drop_d;
    logic            in_range;

    assign in_range = (32'(bus.in_i) < SIZE_U);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        drop_d  = 1'b0;

        if (state_q == S_PULSE) begin
            if (bus.en_i) begin
                drop_d = 1'b1;
            end
            if (cnt_q == '0) begin
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (bus.en_i) begin
            case (bus.mode_i)
                MODE_LEVEL: begin
                    if (in_range) begin
                        idx_d   = bus.in_i;
                        state_d = S_LATCH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                MODE_PULSE: begin
                    if (in_range) begin
                        idx_d   = bus.in_i;
                        cnt_d   = CNT_W'(PULSE_LEN - 1);
                        state_d = S_PULSE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                MODE_STEP: begin
                    // wrap at SIZE-1, not at the natural 2**BITS rollover
                    idx_d   = (idx_q == BITS'(SIZE - 1)) ? '0 : idx_q + BITS'(1);
                    state_d = S_LATCH;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        out_d = (state_d == S_IDLE) ? '0 : (SIZE'(1) << idx_d);
    end

    assign bus.out_o  = out_q;
    assign bus.idx_o  = idx_q;
    assign bus.busy_o = (state_q == S_PULSE);
    assign bus.err_o  = err_q;
    assign bus.drop_o = drop_q;
endmodule

// File: tb/tb_decoder_param_seq.sv
// Bench for decoder_param_seq: directed scenarios on three parameter sets plus
// a randomized run compared against a cycle-level behavioural model.
module tb_decoder_param_seq;
    localparam logic [1:0] M_LEVEL = 2'b00;
    localparam logic [1:0] M_PULSE = 2'b01;
    localparam logic [1:0] M_STEP  = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    decoder_param_seq_if #(.BITS(2), .SIZE(4)) ifa ();
    decoder_param_seq_if #(.BITS(3), .SIZE(5)) ifb ();
    decoder_param_seq_if #(.BITS(2), .SIZE(4)) ifc ();

    decoder_param_seq #(.BITS(2), .SIZE(4), .PULSE_LEN(3), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa));
    decoder_param_seq #(.BITS(3), .SIZE(5), .PULSE_LEN(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb));
    decoder_param_seq #(.BITS(2), .SIZE(4), .PULSE_LEN(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst_c), .bus(ifc));

    // Behavioural model: per DUT, whether a select is shown, which index,
    // how many more cycles the pulse stays visible, and the one-cycle flags.
    int m_size[3]  = '{4, 5, 4};
    int m_plen[3]  = '{3, 4, 1};
    bit m_active[3];
    int m_idx[3];
    int m_rem[3];
    bit m_err[3];
    bit m_drop[3];

    task automatic model_step(int d, bit r, bit en, logic [1:0] mode, int in);
        m_err[d]  = 1'b0;
        m_drop[d] = 1'b0;
        if (r) begin
            m_active[d] = 1'b0;
            m_idx[d]    = 0;
            m_rem[d]    = 0;
        end else if (m_rem[d] > 0) begin
            if (en) m_drop[d] = 1'b1;
            m_rem[d]--;
            if (m_rem[d] == 0) m_active[d] = 1'b0;
        end else if (en) begin
            if (mode == M_LEVEL || mode == M_PULSE) begin
                if (in < m_size[d]) begin
                    m_idx[d]    = in;
                    m_active[d] = 1'b1;
                    if (mode == M_PULSE) m_rem[d] = m_plen[d];
                end else begin
                    m_err[d]    = 1'b1;
                    m_active[d] = 1'b0;
                end
            end else if (mode == M_STEP) begin
                m_idx[d]    = (m_idx[d] + 1) % m_size[d];
                m_active[d] = 1'b1;
            end else begin
                m_active[d] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(bit en, logic [1:0] mode, logic [1:0] in);
        ifa.en_i = en; ifa.mode_i = mode; ifa.in_i = in;
    endtask

    task automatic drive_b(bit en, logic [1:0] mode, logic [2:0] in);
        ifb.en_i = en; ifb.mode_i = mode; ifb.in_i = in;
    endtask

    task automatic drive_c(bit en, logic [1:0] mode, logic [1:0] in);
        ifc.en_i = en; ifc.mode_i = mode; ifc.in_i = in;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        drive_a(1'b1, M_LEVEL, 2'd3);
        tick();
        tick();
        rst_a = 1'b0;
        drive_a(1'b0, M_LEVEL, 2'd0);
        checks++;
        if (ifa.out_o !== 4'b0000 || ifa.idx_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_out_idx got out=%b idx=%0d exp out=0000 idx=0", ifa.out_o, ifa.idx_o);
        end
        checks++;
        if (ifa.busy_o !== 1'b0 || ifa.err_o !== 1'b0 || ifa.drop_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b err=%b drop=%b exp 0 0 0", ifa.busy_o, ifa.err_o, ifa.drop_o);
        end
    endtask

    task automatic test_level();
        int bad = 0;
        drive_a(1'b1, M_LEVEL, 2'd2);
        tick();
        drive_a(1'b0, M_LEVEL, 2'd0);
        checks++;
        if (ifa.out_o !== 4'b0100 || ifa.idx_o !== 2'd2 || ifa.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL level_select got out=%b idx=%0d busy=%b exp 0100 2 0", ifa.out_o, ifa.idx_o, ifa.busy_o);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifa.out_o !== 4'b0100) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL level_hold got %0d bad cycles exp 0", bad);
        end
        drive_a(1'b1, M_CLEAR, 2'd1);
        tick();
        drive_a(1'b0, M_LEVEL, 2'd0);
        checks++;
        if (ifa.out_o !== 4'b0000 || ifa.idx_o !== 2'd2) begin
            failures++;
            $display("FAIL clear got out=%b idx=%0d exp 0000 2", ifa.out_o, ifa.idx_o);
        end
    endtask

    task automatic test_pulse();
        int high = 0;
        drive_a(1'b1, M_PULSE, 2'd1);
        tick();
        drive_a(1'b0, M_LEVEL, 2'd0);
        if (ifa.out_o === 4'b0010 && ifa.busy_o === 1'b1) high++;
        tick();
        if (ifa.out_o === 4'b0010 && ifa.busy_o === 1'b1) high++;
        drive_a(1'b1, M_LEVEL, 2'd3);
        tick();
        drive_a(1'b0, M_LEVEL, 2'd0);
        if (ifa.out_o === 4'b0010 && ifa.busy_o === 1'b1) high++;
        checks++;
        if (ifa.drop_o !== 1'b1) begin
            failures++;
            $display("FAIL pulse_drop got drop=%b exp 1", ifa.drop_o);
        end
        tick();
        checks++;
        if (high != 3) begin
            failures++;
            $display("FAIL pulse_len got %0d high cycles exp 3", high);
        end
        checks++;
        if (ifa.out_o !== 4'b0000 || ifa.busy_o !== 1'b0 || ifa.drop_o !== 1'b0 || ifa.idx_o !== 2'd1) begin
            failures++;
            $display("FAIL pulse_end got out=%b busy=%b drop=%b idx=%0d exp 0000 0 0 1",
                     ifa.out_o, ifa.busy_o, ifa.drop_o, ifa.idx_o);
        end
        drive_a(1'b1, M_LEVEL, 2'd3);
        tick();
        drive_a(1'b0, M_LEVEL, 2'd0);
        checks++;
        if (ifa.out_o !== 4'b1000) begin
            failures++;
            $display("FAIL pulse_after_accept got out=%b exp 1000", ifa.out_o);
        end
    endtask

    task automatic test_step();
        logic [3:0] exp_out;
        int exp_idx;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, M_STEP, 2'($urandom_range(0, 3)));
            tick();
            exp_idx = (i + 1) % 4;
            exp_out = 4'b0001 << exp_idx;
            checks++;
            if (ifa.out_o !== exp_out || 32'(ifa.idx_o) != exp_idx) begin
                failures++;
                $display("FAIL step_%0d got out=%b idx=%0d exp out=%b idx=%0d",
                         i, ifa.out_o, ifa.idx_o, exp_out, exp_idx);
            end
        end
        drive_a(1'b0, M_LEVEL, 2'd0);
    endtask

    task automatic test_err();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        drive_b(1'b1, M_LEVEL, 3'd4);
        tick();
        drive_b(1'b1, M_LEVEL, 3'd6);
        tick();
        drive_b(1'b0, M_LEVEL, 3'd0);
        checks++;
        if (ifb.err_o !== 1'b1 || ifb.out_o !== 5'b00000 || ifb.idx_o !== 3'd4) begin
            failures++;
            $display("FAIL err_level got err=%b out=%b idx=%0d exp 1 00000 4", ifb.err_o, ifb.out_o, ifb.idx_o);
        end
        tick();
        checks++;
        if (ifb.err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_clears got err=%b exp 0", ifb.err_o);
        end
        drive_b(1'b1, M_STEP, 3'd7);
        tick();
        drive_b(1'b0, M_LEVEL, 3'd0);
        checks++;
        if (ifb.idx_o !== 3'd0 || ifb.out_o !== 5'b00001 || ifb.err_o !== 1'b0) begin
            failures++;
            $display("FAIL step_wrap5 got idx=%0d out=%b err=%b exp 0 00001 0", ifb.idx_o, ifb.out_o, ifb.err_o);
        end
        drive_b(1'b1, M_PULSE, 3'd5);
        tick();
        drive_b(1'b0, M_LEVEL, 3'd0);
        checks++;
        if (ifb.err_o !== 1'b1 || ifb.busy_o !== 1'b0 || ifb.out_o !== 5'b00000) begin
            failures++;
            $display("FAIL err_pulse got err=%b busy=%b out=%b exp 1 0 00000", ifb.err_o, ifb.busy_o, ifb.out_o);
        end
    endtask

    task automatic test_reset_mid_pulse();
        drive_b(1'b1, M_PULSE, 3'd2);
        tick();
        drive_b(1'b0, M_LEVEL, 3'd0);
        tick();
        checks++;
        if (ifb.busy_o !== 1'b1 || ifb.out_o !== 5'b00100) begin
            failures++;
            $display("FAIL midpulse_pre got busy=%b out=%b exp 1 00100", ifb.busy_o, ifb.out_o);
        end
        rst_b = 1'b1;
        drive_b(1'b1, M_LEVEL, 3'd1);
        tick();
        rst_b = 1'b0;
        drive_b(1'b0, M_LEVEL, 3'd0);
        checks++;
        if (ifb.out_o !== 5'b00000 || ifb.busy_o !== 1'b0 || ifb.idx_o !== 3'd0 || ifb.drop_o !== 1'b0) begin
            failures++;
            $display("FAIL midpulse_rst got out=%b busy=%b idx=%0d drop=%b exp 00000 0 0 0",
                     ifb.out_o, ifb.busy_o, ifb.idx_o, ifb.drop_o);
        end
    endtask

    task automatic test_pulse_len1();
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        drive_c(1'b1, M_PULSE, 2'd3);
        tick();
        drive_c(1'b1, M_LEVEL, 2'd1);
        checks++;
        if (ifc.out_o !== 4'b1000 || ifc.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL pulse1_on got out=%b busy=%b exp 1000 1", ifc.out_o, ifc.busy_o);
        end
        tick();
        drive_c(1'b0, M_LEVEL, 2'd0);
        checks++;
        if (ifc.out_o !== 4'b0000 || ifc.busy_o !== 1'b0 || ifc.drop_o !== 1'b1) begin
            failures++;
            $display("FAIL pulse1_off got out=%b busy=%b drop=%b exp 0000 0 1", ifc.out_o, ifc.busy_o, ifc.drop_o);
        end
    endtask

    task automatic test_random();
        bit r, ea, eb;
        logic [1:0] ma, mb;
        int ia, ib;
        logic [7:0] exp_a, exp_b;
        rst_a = 1'b1; rst_b = 1'b1;
        tick();
        model_step(0, 1'b1, 1'b0, M_LEVEL, 0);
        model_step(1, 1'b1, 1'b0, M_LEVEL, 0);
        for (int cyc = 0; cyc < 5000; cyc++) begin
            r  = ($urandom_range(0, 199) == 0);
            ea = ($urandom_range(0, 9) < 7);
            eb = ($urandom_range(0, 9) < 7);
            ma = 2'($urandom_range(0, 3));
            mb = 2'($urandom_range(0, 3));
            ia = $urandom_range(0, 3);
            ib = $urandom_range(0, 7);
            rst_a = r; rst_b = r;
            drive_a(ea, ma, 2'(ia));
            drive_b(eb, mb, 3'(ib));
            tick();
            model_step(0, r, ea, ma, ia);
            model_step(1, r, eb, mb, ib);
            exp_a = m_active[0] ? (8'd1 << m_idx[0]) : 8'd0;
            exp_b = m_active[1] ? (8'd1 << m_idx[1]) : 8'd0;
            checks++;
            if (ifa.out_o !== exp_a[3:0] || 32'(ifa.idx_o) != m_idx[0] || ifa.busy_o !== (m_rem[0] > 0)
                || ifa.err_o !== m_err[0] || ifa.drop_o !== m_drop[0]) begin
                failures++;
                $display("FAIL rand_a cyc=%0d got out=%b idx=%0d busy=%b err=%b drop=%b exp out=%b idx=%0d busy=%b err=%b drop=%b",
                         cyc, ifa.out_o, ifa.idx_o, ifa.busy_o, ifa.err_o, ifa.drop_o,
                         exp_a[3:0], m_idx[0], (m_rem[0] > 0), m_err[0], m_drop[0]);
            end
            checks++;
            if (ifb.out_o !== exp_b[4:0] || 32'(ifb.idx_o) != m_idx[1] || ifb.busy_o !== (m_rem[1] > 0)
                || ifb.err_o !== m_err[1] || ifb.drop_o !== m_drop[1]) begin
                failures++;
                $display("FAIL rand_b cyc=%0d got out=%b idx=%0d busy=%b err=%b drop=%b exp out=%b idx=%0d busy=%b err=%b drop=%b",
                         cyc, ifb.out_o, ifb.idx_o, ifb.busy_o, ifb.err_o, ifb.drop_o,
                         exp_b[4:0], m_idx[1], (m_rem[1] > 0), m_err[1], m_drop[1]);
            end
            checks++;
            if ($countones(ifa.out_o) > 1 || $countones(ifb.out_o) > 1) begin
                failures++;
                $display("FAIL rand_onehot cyc=%0d got a=%b b=%b exp at most one bit", cyc, ifa.out_o, ifb.out_o);
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
        drive_a(1'b0, M_LEVEL, 2'd0);
        drive_b(1'b0, M_LEVEL, 3'd0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        drive_a(1'b0, M_LEVEL, 2'd0);
        drive_b(1'b0, M_LEVEL, 3'd0);
        drive_c(1'b0, M_LEVEL, 2'd0);
        tick();
        rst_b = 1'b0; rst_c = 1'b0;
        test_reset();
        test_level();
        test_pulse();
        test_step();
        test_err();
        test_reset_mid_pulse();
        test_pulse_len1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
